// File: rtl/crossing_block_decoder.sv
// Receive-side decoder for a crossing-block link: recovers (i1, i2) from (o1, o1+i2) and buffers them in a FIFO.
// Define CROSSING_BLOCK_DECODER_STATS_EN to add a saturating completed-pop counter (io_stat_pops).
module crossing_block_decoder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       io_in_valid,
    output logic                       io_in_ready,
    input  logic [WIDTH-1:0]           io_in_o1,
    input  logic [WIDTH-1:0]           io_in_o2,
    output logic                       io_out_valid,
    input  logic                       io_out_ready,
    output logic [WIDTH-1:0]           io_out_i1,
    output logic [WIDTH-1:0]           io_out_i2,
`ifdef CROSSING_BLOCK_DECODER_STATS_EN
    output logic [15:0]                io_stat_pops,
`endif
    output logic [$clog2(DEPTH):0]     io_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] i1;
        logic [WIDTH-1:0] i2;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   count;
    logic            push, pop;
    entry_t          dec;

    // Full/empty come from count alone, so pointer equality is never ambiguous.
    assign io_in_ready  = (count != CW'(DEPTH));
    assign io_out_valid = (count != '0);
    assign push         = io_in_valid && io_in_ready;
    assign pop          = io_out_valid && io_out_ready;
    assign io_count     = count;

    assign dec.i1    = io_in_o1;
    assign dec.i2    = io_in_o2 - io_in_o1;
    assign io_out_i1 = mem[rptr].i1;
    assign io_out_i2 = mem[rptr].i2;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= dec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef CROSSING_BLOCK_DECODER_STATS_EN
    logic [15:0] pops_q;
    assign io_stat_pops = pops_q;

    always_ff @(posedge clk) begin
        if (reset)                         pops_q <= '0;
        else if (pop && pops_q != 16'hFFFF) pops_q <= pops_q + 16'd1;
    end
`endif
endmodule

// File: tb/tb_crossing_block_decoder.sv
// Directed bench for crossing_block_decoder: decode arithmetic, full/empty edges, wrap, reset flush.
module tb_crossing_block_decoder;
    logic       clk = 1'b0;
    logic       reset;
    logic       io_in_valid, io_in_ready;
    logic [7:0] io_in_o1, io_in_o2;
    logic       io_out_valid, io_out_ready;
    logic [7:0] io_out_i1, io_out_i2;
    logic [2:0] io_count;
`ifdef CROSSING_BLOCK_DECODER_STATS_EN
    logic [15:0] io_stat_pops;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q [$];
    logic [7:0] e1;

    crossing_block_decoder #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_in_o1(io_in_o1), .io_in_o2(io_in_o2),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_out_i1(io_out_i1), .io_out_i2(io_out_i2),
`ifdef CROSSING_BLOCK_DECODER_STATS_EN
        .io_stat_pops(io_stat_pops),
`endif
        .io_count(io_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] o1, input logic [7:0] o2);
        io_in_valid = 1'b1; io_in_o1 = o1; io_in_o2 = o2;
        step();
        io_in_valid = 1'b0;
    endtask

    task automatic pop_one();
        io_out_ready = 1'b1;
        step();
        io_out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        io_in_valid = 0; io_out_ready = 0; io_in_o1 = 0; io_in_o2 = 0;
        do_reset();
        chk("rst_count", io_count, 0);
        chk("rst_valid", io_out_valid, 0);
        chk("rst_ready", io_in_ready, 1);

        // basic decode
        push_one(8'h12, 8'h45);
        chk("basic_valid", io_out_valid, 1);
        chk("basic_i1", io_out_i1, 8'h12);
        chk("basic_i2", io_out_i2, 8'h33);
        chk("basic_count", io_count, 1);
        pop_one();
        chk("basic_empty", io_out_valid, 0);

        // subtraction wraps mod 256
        push_one(8'hF0, 8'h10);
        chk("wrap_i1", io_out_i1, 8'hF0);
        chk("wrap_i2", io_out_i2, 8'h20);
        pop_one();
        push_one(8'h05, 8'h05);
        chk("zero_i2", io_out_i2, 8'h00);
        pop_one();

        // fill to full, then an ignored 5th push
        for (int k = 1; k <= 4; k++) push_one(8'(k), 8'(2 * k));
        chk("full_count", io_count, 4);
        chk("full_ready", io_in_ready, 0);
        push_one(8'h99, 8'h99);
        chk("full_ignored", io_count, 4);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_valid", io_out_valid, 1);
            chk("drain_i1", io_out_i1, 8'(k));
            chk("drain_i2", io_out_i2, 8'(k));
            pop_one();
            if (k == 1) chk("ready_after_pop", io_in_ready, 1);
        end
        chk("drain_empty", io_out_valid, 0);
        chk("drain_count", io_count, 0);

        // steady push+pop at occupancy 2; pointers wrap several times
        push_one(8'hA0, 8'hA7); exp_q.push_back(8'hA0);
        push_one(8'hA1, 8'hA8); exp_q.push_back(8'hA1);
        for (int k = 0; k < 10; k++) begin
            io_in_valid = 1'b1; io_out_ready = 1'b1;
            io_in_o1 = 8'(k); io_in_o2 = 8'(k) + 8'h07;
            e1 = exp_q.pop_front();
            chk("sim_i1", io_out_i1, e1);
            chk("sim_i2", io_out_i2, 8'h07);
            exp_q.push_back(8'(k));
            step();
            chk("sim_count", io_count, 2);
        end
        io_in_valid = 1'b0; io_out_ready = 1'b0;
        while (exp_q.size() > 0) begin
            e1 = exp_q.pop_front();
            chk("sim_tail_i1", io_out_i1, e1);
            pop_one();
        end
        chk("sim_empty", io_out_valid, 0);

        // reset with three entries queued and a push attempted
        for (int k = 0; k < 3; k++) push_one(8'h31 + 8'(k), 8'h40);
        chk("pre_rst_count", io_count, 3);
        reset = 1'b1; io_in_valid = 1'b1; io_in_o1 = 8'h77; io_in_o2 = 8'h77;
        step();
        reset = 1'b0; io_in_valid = 1'b0;
        chk("mid_rst_count", io_count, 0);
        chk("mid_rst_valid", io_out_valid, 0);
        chk("mid_rst_ready", io_in_ready, 1);
        push_one(8'h55, 8'h60);
        chk("post_rst_i1", io_out_i1, 8'h55);
        chk("post_rst_i2", io_out_i2, 8'h0B);
        chk("post_rst_count", io_count, 1);
        pop_one();
        chk("post_rst_empty", io_out_valid, 0);

`ifdef CROSSING_BLOCK_DECODER_STATS_EN
        do_reset();
        chk("stat_rst", io_stat_pops, 0);
        for (int k = 0; k < 5; k++) begin
            push_one(8'(k), 8'(k));
            pop_one();
        end
        chk("stat_five", io_stat_pops, 5);
        push_one(8'h01, 8'h01);
        io_in_valid = 1'b1; io_out_ready = 1'b1;
        for (int k = 0; k < 70000; k++) step();
        io_in_valid = 1'b0; io_out_ready = 1'b0;
        chk("stat_sat", io_stat_pops, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/crossing_block_decoder.md
Name: crossing_block_decoder

Overview:
- Inverse of the crossing block's encode path. The encoder produces o1 = i1 and o2 = o1 + i2.
- This block takes encoded (o1, o2) pairs over a valid/ready handshake and recovers i1 = o1 and i2 = o2 - o1.
- Decoded pairs are buffered in a small FIFO and presented downstream on a valid/ready handshake.
- Sits at the receive end of a crossing-block link, between the link and the consumer.

Parameters:
- WIDTH, 8, data width of every o/i field.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  synchronous, active-high.
- io_in_valid  input  1  encoded pair present.
- io_in_ready  output  1  block can accept the pair this cycle.
- io_in_o1  input  WIDTH  encoded o1 (equals original i1).
- io_in_o2  input  WIDTH  encoded o2 (o1 + i2 mod 2^WIDTH).
- io_out_valid  output  1  decoded pair available at FIFO head.
- io_out_ready  input  1  consumer accepts head this cycle.
- io_out_i1  output  WIDTH  decoded i1.
- io_out_i2  output  WIDTH  decoded i2.
- io_count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Sampled on the clk rising edge only.
- Reset values: io_out_valid=0, io_count=0, io_in_ready=1, read/write pointers=0. io_out_i1/io_out_i2 read mem[0] and are don't-care while io_out_valid=0.
- Decode is done at enqueue:
  - stored i1 = io_in_o1;
  - stored i2 = (io_in_o2 - io_in_o1) truncated to WIDTH bits (mod 2^WIDTH, no borrow out).
- Push: io_in_valid && io_in_ready. Entry written at wptr; wptr increments and wraps at DEPTH.
- Pop: io_out_valid && io_out_ready. rptr increments and wraps at DEPTH.
- io_in_ready = (count != DEPTH). It is combinational from registered count only, with no dependence on io_out_ready, so there is no ready pass-through when full.
- io_out_valid = (count != 0). Outputs come from mem[rptr], registered state only.
- Latency: a pair pushed in cycle N appears at the head with io_out_valid=1 in cycle N+1 at earliest. There is no same-cycle bypass when empty.
- Occupancy:
  - push only: count+1;
  - pop only: count-1;
  - push and pop in the same cycle: count unchanged, both pointers advance.
- Full (count=DEPTH):
  - io_in_ready=0; io_in_valid is ignored and no write occurs;
  - a pop that cycle frees a slot, but io_in_ready rises only in the next cycle.
- Empty (count=0):
  - io_out_valid=0; io_out_ready is ignored and the pointers do not move;
  - a push that cycle sets io_out_valid in the next cycle.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count, not by pointer equality.
- Reset mid-operation: all entries are discarded. On the cycle after reset deasserts, count=0, io_out_valid=0 and io_in_ready=1, regardless of prior state or handshakes asserted during reset.
- Data ordering: strict FIFO order; no reordering or dropping while handshakes are honoured.

Optional Feature:
- Macro: CROSSING_BLOCK_DECODER_STATS_EN.
- When defined:
  - adds output port io_stat_pops (16 bits), a counter of completed pops;
  - increments by 1 per pop and saturates at 16'hFFFF (no wrap);
  - cleared to 0 by reset.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Basic decode: reset, then push o1=8'h12, o2=8'h45 with io_out_ready=0. Required: next cycle io_out_valid=1, io_out_i1=8'h12, io_out_i2=8'h33, io_count=1.
- Underflow wrap: push o1=8'hF0, o2=8'h10. Required: io_out_i1=8'hF0, io_out_i2=8'h20. Also push o1=8'h05, o2=8'h05. Required: io_out_i2=8'h00.
- Fill to full: with io_out_ready=0, push 4 pairs (o1=k, o2=2k for k=1..4). Required:
  - io_count=4 and io_in_ready=0;
  - a 5th push is ignored;
  - draining yields i2 = 1,2,3,4 in order, then io_out_valid=0.
- Simultaneous push/pop: hold io_count=2, assert both handshakes for 10 cycles with o1=k, o2=k+8'h07. Required:
  - io_count stays 2 throughout;
  - outputs keep FIFO order with i2=8'h07;
  - pointers wrap past DEPTH without corruption.
- Reset mid-stream: at io_count=3, assert reset for 1 cycle while io_in_valid=1. Required: next cycle io_count=0, io_out_valid=0, io_in_ready=1, and no stale data emerges later.
- Stats (with CROSSING_BLOCK_DECODER_STATS_EN): perform 5 pops. Required: io_stat_pops=5. Force the counter near 16'hFFFF via 70000 pops. Required: it holds at 16'hFFFF.
